// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Definitions shared by the multiply/HI-LO unit and the instruction decoder.
//   mult_state_e : sequencer states (IDLE, RUN, FINISH)
//   MC_*         : multcont encodings driven by the decoder for MFHI/MFLO
//   FUNCT_MULTU  : R-type funct field of the unsigned multiply
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } mult_state_e;

  localparam logic [1:0] MC_NONE = 2'b00;
  localparam logic [1:0] MC_HI   = 2'b01;
  localparam logic [1:0] MC_LO   = 2'b10;

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

endpackage

// File: rtl/mult_shift_add.sv
// ---------------------------------------------------------------------------
// mult_shift_add
// Shift-add datapath for an unsigned WIDTH x WIDTH multiply. Holds the
// multiplicand and the running product; one step per cycle while step_i.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (clears registers)
//   load_i           : capture multiplicand_i, place multiplier_i in the low
//                      half of the product and clear the upper half
//   step_i           : perform one conditional-add-then-shift iteration
//   multiplicand_i   : operand A (rs)
//   multiplier_i     : operand B (rt)
//   product_o        : current 2*WIDTH-bit product register
// ---------------------------------------------------------------------------
module mult_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     upperSum;

  // Next-state for the datapath. The adder produces a WIDTH+1-bit upper half
  // whose carry bit becomes the top of the (2*WIDTH+1)-bit product; after the
  // right shift that carry lands in bit 2*WIDTH-1 and the top bit is always
  // zero, so only 2*WIDTH bits need to be stored between steps.
  always_comb begin
    upperSum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) begin
      upperSum = upperSum + {1'b0, mcand_q};
    end
    prod_d  = prod_q;
    mcand_d = mcand_q;
    if (load_i) begin
      mcand_d = multiplicand_i;
      prod_d  = {{WIDTH{1'b0}}, multiplier_i};
    end else if (step_i) begin
      prod_d = {upperSum, prod_q[WIDTH-1:1]};
    end
  end

  // Product and multiplicand registers; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q  <= '0;
      mcand_q <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
    end
  end

  assign product_o = prod_q;

endmodule

// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer
// Multi-cycle controller for multu and owner of the HI/LO register pair.
// Sequences the shift-add datapath over WIDTH cycles, serves MFHI/MFLO reads
// and stalls the single-cycle core when a dependent instruction shows up
// while a multiply is still in flight.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : decoded multu present this cycle
//   opa, opb   : multiplicand (rs) and multiplier (rt)
//   multcont   : 01 read HI, 10 read LO, 00 none, 11 behaves as 01
//   busy       : multiply in progress (state != IDLE)
//   done       : one-cycle pulse in the cycle HI/LO are written
//   stall      : hold PC and suppress writeback this cycle
//   mf_data    : HI or LO selected by multcont (combinational)
//   hi, lo     : current HI and LO registers
// ---------------------------------------------------------------------------
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [1:0]       multcont,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  mult_state_e        state_q;
  logic [CNT_W-1:0]   count_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [2*WIDTH-1:0] product;
  logic               loadOperands;
  logic               stepProduct;

  // Operands are only captured from IDLE, so a start arriving while busy
  // leaves the multiply in flight untouched.
  assign loadOperands = (state_q == IDLE) && start;
  assign stepProduct  = (state_q == RUN);

  mult_shift_add #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk           (clk),
    .reset         (reset),
    .load_i        (loadOperands),
    .step_i        (stepProduct),
    .multiplicand_i(opa),
    .multiplier_i  (opb),
    .product_o     (product)
  );

  // Sequencer FSM with registered busy/done. done is raised on the way into
  // FINISH so it is high exactly in the cycle whose closing edge writes HI/LO;
  // busy drops at that same edge so a back-to-back start is accepted in the
  // very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          count_q <= count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          hi_q    <= product[2*WIDTH-1:WIDTH];
          lo_q    <= product[WIDTH-1:0];
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Any multiply-related instruction presented while busy must wait; this
  // includes the FINISH cycle because HI/LO only settle at its closing edge.
  assign stall = busy_q && (start || (multcont != MC_NONE));

  // multcont[0] picks HI, which also makes the unused 11 code read HI.
  assign mf_data = multcont[0] ? hi_q : lo_q;

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Multi-cycle controller for the unsigned multiply (`multu`, R-type funct 011001) and the HI/LO register pair.
- Sequences a shift-add datapath over WIDTH cycles, owns HI/LO, and serves MFHI/MFLO reads (multcont 01/10).
- Raises a stall to the single-cycle core while a multiply is in flight and a dependent instruction is presented.
- Sits beside the ALU. It is driven by the decoder's multiply/multcont controls and by register-file read data A/B.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  decoded multu instruction present this cycle.
- opa  in  WIDTH  multiplicand (rs value).
- opb  in  WIDTH  multiplier (rt value).
- multcont  in  2  01 = read HI, 10 = read LO, 00 = none, 11 = treat as 01.
- busy  out  1  multiply in progress (state != IDLE).
- done  out  1  one-cycle pulse in the cycle HI/LO are updated.
- stall  out  1  hold the PC and suppress register writeback this cycle.
- mf_data  out  WIDTH  HI or LO selected by multcont; combinational.
- hi  out  WIDTH  current HI register.
- lo  out  WIDTH  current LO register.

Behaviour:
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 latches opa into the multiplicand register and opb into the low half of the product register.
  - Clears the upper half of the product plus its carry bit, sets count=0, and goes to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle:
  - If product[0]=1, product[2W:W] = product[2W-1:W] + multiplicand (W+1-bit sum).
  - Then the whole (2W+1)-bit product shifts right by 1, and count increments.
  - When count reaches WIDTH-1 in this cycle, the next state is FINISH.
- FINISH (one cycle):
  - hi <= product[2W-1:W], lo <= product[W-1:0], done=1.
  - Next state is IDLE.
- Latency:
  - start sampled at edge 0; RUN occupies edges 1..WIDTH; FINISH at edge WIDTH+1.
  - New HI/LO are visible after edge WIDTH+1, i.e. 33 cycles for WIDTH=32.
- HI/LO are unchanged until FINISH; reads during RUN see the previous result.
- Stall:
  - stall = busy & (start | multcont != 00).
  - Stall is therefore also high during the FINISH cycle, because the register update lands at that cycle's edge.
- start while busy: ignored. The operands are not re-latched, and the stalled core re-presents the instruction once the block is back in IDLE.
- mf_data = hi when multcont[0]=1, else lo. Valid whenever stall=0.
- Arithmetic: unsigned only; no overflow detection. The full 2W-bit product is always exact.
- Reset (any state, including mid-RUN):
  - state=IDLE, count=0, and the product/multiplicand registers are cleared.
  - hi=0, lo=0, busy=0, done=0, stall=0.
  - An aborted multiply never writes HI/LO.
- Back-to-back: a start in the first IDLE cycle after FINISH is accepted immediately, with no bubble beyond the FINISH cycle.

Decomposition:
- Shared package mult_pkg holds:
  - state enum {IDLE, RUN, FINISH};
  - multcont encodings MC_NONE=00, MC_HI=01, MC_LO=10;
  - the FUNCT_MULTU=011001 constant, shared with the decoder.
- Natural sub-module mult_shift_add: the product and multiplicand registers plus the adder.
  - Controls: load, step.
  - Output: product.
- mult_sequencer keeps the FSM, counter, HI/LO registers, stall logic and the read mux.

Test Plan:
- Basic multiply: reset, then start with opa=3, opb=5 → busy high for 33 cycles; done pulses at edge 33; hi=0x00000000, lo=0x0000000F; busy=0 afterwards.
- Full-range operands: opa=opb=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Also opa=0x80000000, opb=2 → hi=0x00000001, lo=0x00000000.
- Read stall: hold multcont=01 from cycle 1 of a 0x10000*0x10000 multiply → stall=1 through the FINISH cycle, then stall=0 and mf_data=0x00000001. A multcont=10 read in the next cycle returns 0.
- Start while busy: during RUN, apply start with opa=7, opb=7 → stall=1 and the operands are ignored. When re-presented in IDLE, the result is lo=49.
- Reset mid-operation: start 9*9, assert reset at RUN cycle 10 → immediately state=IDLE and hi=lo=0; no done pulse follows.
- Back-to-back: start 2*3, then start 4*5 in the first IDLE cycle → lo=6 after the first FINISH and lo=20 after the second, with a 34-cycle spacing between the done pulses.
